// File: rtl/dmem_seq_ctrl.sv
// dmem_seq_ctrl: byte-serial data memory controller.
// A 32-bit load or store is moved one byte per cycle, big-endian, through an
// internal 2**AW byte array. Addresses wrap modulo the memory size.
module dmem_seq_ctrl #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [1:0]    beat;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [23:0]   asm_q;

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] byte_addr;
  logic [7:0]    rd_byte;
  logic [7:0]    wr_byte;
  logic          last_beat;

  // Byte address for the current beat wraps naturally in AW bits
  assign byte_addr = addr_q + AW'(beat);
  assign rd_byte   = mem[byte_addr];
  assign last_beat = (beat == 2'd3);

  // Select the store byte for this beat, most significant byte first
  always_comb begin
    wr_byte = wdata_q[31:24];
    case (beat)
      2'd0:    wr_byte = wdata_q[31:24];
      2'd1:    wr_byte = wdata_q[23:16];
      2'd2:    wr_byte = wdata_q[15:8];
      default: wr_byte = wdata_q[7:0];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs: four transfer beats, one done cycle
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = XFER;
        end
      end
      XFER: begin
        busy = 1'b1;
        if (last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request, count beats and assemble load data into rdata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat    <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      asm_q   <= 24'h0;
      rdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            beat    <= 2'd0;
          end
        end
        XFER: begin
          beat <= beat + 2'd1;
          if (!we_q) begin
            asm_q <= {asm_q[15:0], rd_byte};
            if (last_beat) begin
              rdata <= {asm_q, rd_byte};
            end
          end
        end
        default: begin
          beat <= 2'd0;
        end
      endcase
    end
  end

  // Memory array write port; deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (state == XFER && we_q) begin
      mem[byte_addr] <= wr_byte;
    end
  end

endmodule
